// File: rtl/nmea_pkg.sv
// Shared constants, segment enumeration and field geometry for the GPGGA sentence generator.
package nmea_pkg;

  localparam int unsigned POS_W  = 264;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned IDX_W  = 4;

  localparam logic [BYTE_W-1:0] ASCII_DOLLAR = 8'h24;
  localparam logic [BYTE_W-1:0] ASCII_COMMA  = 8'h2C;
  localparam logic [BYTE_W-1:0] ASCII_STAR   = 8'h2A;
  localparam logic [BYTE_W-1:0] ASCII_CR     = 8'h0D;
  localparam logic [BYTE_W-1:0] ASCII_LF     = 8'h0A;
  localparam logic [63:0]       HDR_STR      = "$GPGGA,,";

  localparam int unsigned LAT_LEN  = 10;
  localparam int unsigned NS_LEN   = 1;
  localparam int unsigned LON_LEN  = 11;
  localparam int unsigned EW_LEN   = 1;
  localparam int unsigned ALT_LEN  = 9;
  localparam int unsigned UNIT_LEN = 1;

  localparam int unsigned UNIT_OFF = 0;
  localparam int unsigned ALT_OFF  = UNIT_OFF + 8 * UNIT_LEN;
  localparam int unsigned EW_OFF   = ALT_OFF + 8 * ALT_LEN;
  localparam int unsigned LON_OFF  = EW_OFF + 8 * EW_LEN;
  localparam int unsigned NS_OFF   = LON_OFF + 8 * LON_LEN;
  localparam int unsigned LAT_OFF  = NS_OFF + 8 * NS_LEN;

  // Sentence segments in transmit order.
  typedef enum logic [4:0] {
    SEG_HDR, SEG_LAT, SEG_C_LAT, SEG_NS, SEG_C_NS, SEG_LON, SEG_C_LON,
    SEG_EW, SEG_C_EW, SEG_FIX, SEG_C_FIX, SEG_SATS, SEG_C_SATS, SEG_ALT,
    SEG_C_ALT, SEG_UNIT, SEG_TAIL, SEG_STAR, SEG_HI, SEG_LO, SEG_CR, SEG_LF,
    SEG_END
  } seg_e;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_SEND, ST_HOLD, ST_WAIT, ST_FIN
  } state_e;

  typedef struct packed {
    logic             is_field;
    logic [8:0]       off;
    logic [IDX_W-1:0] len;
  } fld_t;

  function automatic fld_t fld_info(input seg_e seg);
    fld_t f;
    f = '{is_field: 1'b0, off: 9'd0, len: 4'd1};
    case (seg)
      SEG_LAT:  f = '{1'b1, 9'(LAT_OFF),  4'(LAT_LEN)};
      SEG_NS:   f = '{1'b1, 9'(NS_OFF),   4'(NS_LEN)};
      SEG_LON:  f = '{1'b1, 9'(LON_OFF),  4'(LON_LEN)};
      SEG_EW:   f = '{1'b1, 9'(EW_OFF),   4'(EW_LEN)};
      SEG_ALT:  f = '{1'b1, 9'(ALT_OFF),  4'(ALT_LEN)};
      SEG_UNIT: f = '{1'b1, 9'(UNIT_OFF), 4'(UNIT_LEN)};
      default:  f = '{is_field: 1'b0, off: 9'd0, len: 4'd1};
    endcase
    return f;
  endfunction

  function automatic logic [IDX_W-1:0] seg_len(input seg_e seg);
    case (seg)
      SEG_HDR:    return 4'd8;
      SEG_SATS:   return 4'd2;
      SEG_C_SATS: return 4'd2;
      SEG_TAIL:   return 4'd4;
      default:    return fld_info(seg).len;
    endcase
  endfunction

endpackage

// File: rtl/nmea_hex_nibble.sv
// Combinational 4-bit value to uppercase ASCII hex digit.
module nmea_hex_nibble (
  input  logic [3:0] nibble,
  output logic [7:0] ascii_c
);

  always_comb begin
    if (nibble < 4'd10) ascii_c = 8'h30 + {4'h0, nibble};
    else                ascii_c = 8'h37 + {4'h0, nibble};
  end

endmodule

// File: rtl/nmea_gpgga_tx.sv
// Streams a $GPGGA sentence built from a snapshotted position word into a UART transmitter.
// Optional checksum "*HL" trailer enabled by defining NMEA_CHECKSUM_EN.
module nmea_gpgga_tx
  import nmea_pkg::*;
#(
  parameter logic [7:0]  FIX_QUALITY = "1",
  parameter logic [15:0] NUM_SATS    = "00",
  parameter bit          EMIT_CRLF   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [POS_W-1:0]  position,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [BYTE_W-1:0] tx_data,
  output logic              busy,
  output logic              done
);

  state_e             state, state_n;
  seg_e               seg, adv_seg;
  logic [IDX_W-1:0]   idx, adv_idx;
  logic [POS_W-1:0]   snap;
  logic [BYTE_W-1:0]  cur_byte;
  logic [BYTE_W-1:0]  hex_hi, hex_lo;
  logic [8:0]         bit_pos;
  fld_t               fld;
  logic               skip;
  logic               last_idx;

  function automatic seg_e next_seg(input seg_e s);
    case (s)
      SEG_TAIL: begin
`ifdef NMEA_CHECKSUM_EN
        return SEG_STAR;
`else
        return EMIT_CRLF ? SEG_CR : SEG_END;
`endif
      end
      SEG_LO:  return EMIT_CRLF ? SEG_CR : SEG_END;
      SEG_LF:  return SEG_END;
      SEG_END: return SEG_END;
      default: return seg_e'(s + 5'd1);
    endcase
  endfunction

  // Byte selection for the current segment/index; field bytes come from the snapshot, MSB byte first.
  always_comb begin
    fld      = fld_info(seg);
    bit_pos  = fld.off + 9'({fld.len - 4'd1 - idx, 3'b000});
    cur_byte = ASCII_COMMA;
    case (seg)
      SEG_HDR:  cur_byte = HDR_STR[{3'd7 - idx[2:0], 3'b000} +: 8];
      SEG_FIX:  cur_byte = FIX_QUALITY;
      SEG_SATS: cur_byte = idx[0] ? NUM_SATS[7:0] : NUM_SATS[15:8];
      SEG_STAR: cur_byte = ASCII_STAR;
      SEG_HI:   cur_byte = hex_hi;
      SEG_LO:   cur_byte = hex_lo;
      SEG_CR:   cur_byte = ASCII_CR;
      SEG_LF:   cur_byte = ASCII_LF;
      default:  cur_byte = ASCII_COMMA;
    endcase
    if (fld.is_field) cur_byte = snap[bit_pos +: 8];
    skip     = fld.is_field && (cur_byte == 8'h00);
    last_idx = (idx == seg_len(seg) - 4'd1);
    adv_seg  = last_idx ? next_seg(seg) : seg;
    adv_idx  = last_idx ? '0 : idx + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (start) state_n = ST_FETCH;
      ST_FETCH: if (!skip && !tx_busy) state_n = ST_SEND;
      ST_SEND:  state_n = ST_HOLD;
      ST_HOLD:  state_n = ST_WAIT;
      ST_WAIT:  if (!tx_busy) state_n = (seg == SEG_END) ? ST_FIN : ST_FETCH;
      ST_FIN:   state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // Registered outputs decoded from the next state, plus segment walk and snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_start <= 1'b0;
      tx_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      seg      <= SEG_HDR;
      idx      <= '0;
      snap     <= '0;
    end else begin
      tx_start <= (state_n == ST_SEND);
      busy     <= (state_n inside {ST_FETCH, ST_SEND, ST_HOLD, ST_WAIT});
      done     <= (state_n == ST_FIN);
      if (state == ST_IDLE && start) begin
        snap <= position;
        seg  <= SEG_HDR;
        idx  <= '0;
      end else if (state == ST_SEND || (state == ST_FETCH && skip)) begin
        seg  <= adv_seg;
        idx  <= adv_idx;
      end
      if (state == ST_FETCH && state_n == ST_SEND) tx_data <= cur_byte;
    end
  end

`ifdef NMEA_CHECKSUM_EN
  logic [BYTE_W-1:0] chk;
  logic              chk_en;
  logic              in_sum;

  // Everything after '$' up to and including the trailing commas is summed.
  assign in_sum = (seg <= SEG_TAIL) && !(seg == SEG_HDR && idx == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk    <= '0;
      chk_en <= 1'b0;
    end else begin
      if (state == ST_FETCH && state_n == ST_SEND) chk_en <= in_sum;
      if (state == ST_IDLE && start)               chk    <= '0;
      else if (state == ST_SEND && chk_en)         chk    <= chk ^ tx_data;
    end
  end

  nmea_hex_nibble u_hex_hi (.nibble(chk[7:4]), .ascii_c(hex_hi));
  nmea_hex_nibble u_hex_lo (.nibble(chk[3:0]), .ascii_c(hex_lo));
`else
  assign hex_hi = ASCII_STAR;
  assign hex_lo = ASCII_STAR;
`endif

endmodule

// File: tb/tb_nmea_gpgga_tx.sv
// Directed bench for nmea_gpgga_tx with a UART busy responder; follows NMEA_CHECKSUM_EN like the RTL.
module tb_nmea_gpgga_tx;

  logic         clk      = 1'b0;
  logic         rst_n    = 1'b0;
  logic         start    = 1'b0;
  logic [263:0] position = '0;
  logic         tx_busy  = 1'b0;
  logic         tx_start;
  logic [7:0]   tx_data;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int  busy_cnt    = 0;
  bit  hold_busy   = 1'b0;
  int  cyc         = 0;
  int  last_strobe = -100;
  int  strobe_viol = 0;
  int  gap_viol    = 0;

  logic [263:0] pos_a, pos_b;

  nmea_gpgga_tx dut (
    .clk(clk), .rst_n(rst_n), .start(start), .position(position),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
    .busy(busy), .done(done)
  );

  always #10 clk = ~clk;

  // UART stand-in: captures each strobe and stays busy 10 cycles per byte.
  always @(negedge clk) begin
    cyc++;
    if (tx_start === 1'b1) begin
      if (tx_busy) strobe_viol++;
      if (cyc - last_strobe < 3) gap_viol++;
      last_strobe = cyc;
      rx_q.push_back(tx_data);
      busy_cnt = 10;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    tx_busy = hold_busy || (busy_cnt > 0);
  end

  function automatic void push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(8'(s[i]));
  endfunction

  function automatic void push_crlf();
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endfunction

  function automatic void push_field(input logic [87:0] f, input int n);
    logic [7:0] b;
    for (int i = n - 1; i >= 0; i--) begin
      b = f[i*8 +: 8];
      if (b != 8'h00) exp_q.push_back(b);
    end
  endfunction

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction

  // Reference sentence built straight from the template.
  function automatic void build_exp(input logic [263:0] p);
    logic [7:0] x;
    exp_q.delete();
    push_str("$GPGGA,,");
    push_field(88'(p[263:184]), 10); push_str(",");
    push_field(88'(p[183:176]), 1);  push_str(",");
    push_field(p[175:88], 11);       push_str(",");
    push_field(88'(p[87:80]), 1);    push_str(",1,00,,");
    push_field(88'(p[79:8]), 9);     push_str(",");
    push_field(88'(p[7:0]), 1);      push_str(",,,,");
`ifdef NMEA_CHECKSUM_EN
    x = 8'h00;
    for (int i = 1; i < exp_q.size(); i++) x ^= exp_q[i];
    exp_q.push_back(8'h2A);
    exp_q.push_back(hexc(x[7:4]));
    exp_q.push_back(hexc(x[3:0]));
`endif
    push_crlf();
  endfunction

  function automatic int first_diff();
    int n;
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (rx_q[i] !== exp_q[i]) return i;
    if (rx_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  task automatic start_sentence(input logic [263:0] p);
    rx_q.delete();
    @(negedge clk);
    position = p;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit pulse_fin,
                           output bit found, output int ndone, output logic busy_at);
    found = 1'b0; ndone = 0; busy_at = 1'bx;
    for (int c = 0; c < budget && !found; c++) begin
      @(negedge clk);
      if (done) begin
        found = 1'b1; ndone = 1; busy_at = busy;
        if (pulse_fin) start = 1'b1;
      end
    end
    @(negedge clk);
    start = 1'b0;
    if (done) ndone++;
    repeat (6) begin
      @(negedge clk);
      if (done) ndone++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (tx_start !== 1'b0) $display("FAIL reset_tx_start got %b want 0", tx_start); else n_pass++;
    n_checks++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data got %h want 00", tx_data); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_zero_position();
    bit found; int nd; logic ba; int d;
    start_sentence('0);
    n_checks++; if (busy !== 1'b1) $display("FAIL zero_busy_rise got %b want 1", busy); else n_pass++;
    wait_done(3000, 1'b0, found, nd, ba);
    n_checks++; if (found !== 1'b1) $display("FAIL zero_done_timeout got %b want 1", found); else n_pass++;
    n_checks++; if (nd !== 1) $display("FAIL zero_done_count got %0d want 1", nd); else n_pass++;
    n_checks++; if (ba !== 1'b0) $display("FAIL zero_busy_at_done got %b want 0", ba); else n_pass++;
    exp_q.delete();
`ifdef NMEA_CHECKSUM_EN
    push_str("$GPGGA,,,,,,1,00,,,,,,,*67");
`else
    push_str("$GPGGA,,,,,,1,00,,,,,,,");
`endif
    push_crlf();
    n_checks++; if (rx_q.size() !== exp_q.size()) $display("FAIL zero_len got %0d want %0d", rx_q.size(), exp_q.size()); else n_pass++;
    d = first_diff();
    n_checks++; if (d !== -1) $display("FAIL zero_bytes at %0d got %h want %h", d, rx_q[d], exp_q[d]); else n_pass++;
  endtask

  task automatic test_nul_skip();
    bit found; int nd; logic ba; int d;
    start_sentence(pos_a);
    wait_done(3000, 1'b0, found, nd, ba);
    n_checks++; if (found !== 1'b1) $display("FAIL nul_done_timeout got %b want 1", found); else n_pass++;
    exp_q.delete();
`ifdef NMEA_CHECKSUM_EN
    push_str("$GPGGA,,2334.5678,S,04647.1234,W,1,00,,0000812.5,M,,,,*31");
`else
    push_str("$GPGGA,,2334.5678,S,04647.1234,W,1,00,,0000812.5,M,,,,");
`endif
    push_crlf();
    d = first_diff();
    n_checks++; if (d !== -1) $display("FAIL nul_literal at %0d got %h want %h", d, rx_q[d], exp_q[d]); else n_pass++;
    build_exp(pos_a);
    d = first_diff();
    n_checks++; if (d !== -1) $display("FAIL nul_model at %0d got %h want %h", d, rx_q[d], exp_q[d]); else n_pass++;
  endtask

  task automatic test_busy_stall();
    bit found; int nd; logic ba; int d; int n0; int c;
    start_sentence(pos_a);
    c = 0;
    while (rx_q.size() < 1 && c < 200) begin @(negedge clk); c++; end
    hold_busy = 1'b1;
    n_checks++; if (rx_q.size() !== 1) $display("FAIL stall_first_strobe got %0d want 1", rx_q.size()); else n_pass++;
    n0 = rx_q.size();
    repeat (1000) @(negedge clk);
    n_checks++; if (rx_q.size() !== n0) $display("FAIL stall_no_strobe got %0d want %0d", rx_q.size(), n0); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL stall_busy got %b want 1", busy); else n_pass++;
    hold_busy = 1'b0;
    wait_done(3000, 1'b0, found, nd, ba);
    n_checks++; if (nd !== 1) $display("FAIL stall_done_count got %0d want 1", nd); else n_pass++;
    build_exp(pos_a);
    d = first_diff();
    n_checks++; if (d !== -1) $display("FAIL stall_bytes at %0d got %h want %h", d, rx_q[d], exp_q[d]); else n_pass++;
  endtask

  task automatic test_restart_ignored();
    bit found; int nd; logic ba; int d; int c;
    start_sentence(pos_a);
    c = 0;
    while (rx_q.size() < 12 && c < 2000) begin @(negedge clk); c++; end
    @(negedge clk);
    position = pos_b;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    wait_done(3000, 1'b0, found, nd, ba);
    n_checks++; if (nd !== 1) $display("FAIL restart_done_count got %0d want 1", nd); else n_pass++;
    build_exp(pos_a);
    d = first_diff();
    n_checks++; if (d !== -1) $display("FAIL restart_bytes at %0d got %h want %h", d, rx_q[d], exp_q[d]); else n_pass++;
  endtask

  task automatic test_reset_abort();
    bit found; int nd; logic ba; int d; int c; int n0; int ndone;
    start_sentence(pos_a);
    c = 0;
    while (rx_q.size() < 22 && c < 3000) begin @(negedge clk); c++; end
    n_checks++; if (rx_q.size() < 22) $display("FAIL abort_reach_lon got %0d want >=22", rx_q.size()); else n_pass++;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if (tx_start !== 1'b0) $display("FAIL abort_tx_start got %b want 0", tx_start); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (tx_data !== 8'h00) $display("FAIL abort_tx_data got %h want 00", tx_data); else n_pass++;
    n0 = rx_q.size();
    ndone = 0;
    repeat (4) begin @(negedge clk); if (done) ndone++; end
    rst_n = 1'b1;
    repeat (30) begin @(negedge clk); if (done) ndone++; end
    n_checks++; if (ndone !== 0) $display("FAIL abort_no_done got %0d want 0", ndone); else n_pass++;
    n_checks++; if (rx_q.size() !== n0) $display("FAIL abort_no_strobe got %0d want %0d", rx_q.size(), n0); else n_pass++;
    start_sentence(pos_b);
    wait_done(3000, 1'b0, found, nd, ba);
    n_checks++; if (nd !== 1) $display("FAIL abort_resend_done got %0d want 1", nd); else n_pass++;
    build_exp(pos_b);
    d = first_diff();
    n_checks++; if (d !== -1) $display("FAIL abort_resend_bytes at %0d got %h want %h", d, rx_q[d], exp_q[d]); else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit found; int nd; logic ba; int d; int n0; int busy_seen;
    start_sentence(pos_b);
    wait_done(3000, 1'b1, found, nd, ba);
    n_checks++; if (nd !== 1) $display("FAIL b2b_done_count got %0d want 1", nd); else n_pass++;
    n0 = rx_q.size();
    busy_seen = 0;
    repeat (30) begin @(negedge clk); if (busy) busy_seen++; end
    n_checks++; if (rx_q.size() !== n0) $display("FAIL fin_start_strobes got %0d want %0d", rx_q.size(), n0); else n_pass++;
    n_checks++; if (busy_seen !== 0) $display("FAIL fin_start_busy got %0d want 0", busy_seen); else n_pass++;
    start_sentence('0);
    wait_done(3000, 1'b0, found, nd, ba);
    n_checks++; if (found !== 1'b1) $display("FAIL b2b_second_done got %b want 1", found); else n_pass++;
    build_exp('0);
    d = first_diff();
    n_checks++; if (d !== -1) $display("FAIL b2b_second_bytes at %0d got %h want %h", d, rx_q[d], exp_q[d]); else n_pass++;
  endtask

  initial begin
    pos_a = {8'h00, "2334.5678", "S", 8'h00, "04647.1234", "W", "0000812.5", "M"};
    pos_b = {8'h00, "1111.9876", "N", 8'h00, "02222.4321", "E", 8'h00, 8'h00, "00099.9", "F"};
    test_reset();
    test_zero_position();
    test_nul_skip();
    test_busy_stall();
    test_restart_ignored();
    test_reset_abort();
    test_back_to_back();
    n_checks++; if (strobe_viol !== 0) $display("FAIL strobe_while_busy got %0d want 0", strobe_viol); else n_pass++;
    n_checks++; if (gap_viol !== 0) $display("FAIL strobe_gap got %0d want 0", gap_viol); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
